// File: rtl/busytable_ckpt_if.sv
// rtl/busytable_ckpt_if.sv - busy table request/response bundle
interface busytable_ckpt_if #(
    parameter int PREG_W      = 6,
    parameter int RD_PORTS    = 4,
    parameter int ALLOC_PORTS = 2,
    parameter int WB_PORTS    = 2,
    parameter int NUM_CKPT    = 4,
    parameter int CKPT_W      = 2
);
    logic [RD_PORTS*PREG_W-1:0]    read_addr;
    logic [RD_PORTS-1:0]           busy_out;
    logic [ALLOC_PORTS-1:0]        alloc_en;
    logic [ALLOC_PORTS*PREG_W-1:0] alloc_addr;
    logic [WB_PORTS-1:0]           wb_en;
    logic [WB_PORTS*PREG_W-1:0]    wb_addr;
    logic                          ckpt_take;
    logic [CKPT_W-1:0]             ckpt_take_id;
    logic [ALLOC_PORTS-1:0]        ckpt_take_mask;
    logic                          ckpt_release;
    logic [CKPT_W-1:0]             ckpt_release_id;
    logic                          restore_en;
    logic [CKPT_W-1:0]             restore_id;
    logic [NUM_CKPT-1:0]           restore_kill_mask;
    logic                          flush;
    logic [NUM_CKPT-1:0]           ckpt_valid;
    logic                          ckpt_error;

    modport master (
        output read_addr, alloc_en, alloc_addr, wb_en, wb_addr,
               ckpt_take, ckpt_take_id, ckpt_take_mask,
               ckpt_release, ckpt_release_id,
               restore_en, restore_id, restore_kill_mask, flush,
        input  busy_out, ckpt_valid, ckpt_error
    );

    modport slave (
        input  read_addr, alloc_en, alloc_addr, wb_en, wb_addr,
               ckpt_take, ckpt_take_id, ckpt_take_mask,
               ckpt_release, ckpt_release_id,
               restore_en, restore_id, restore_kill_mask, flush,
        output busy_out, ckpt_valid, ckpt_error
    );
endinterface

// File: rtl/busytable_ckpt.sv
// rtl/busytable_ckpt.sv - physical register busy table with per-branch checkpoints
module busytable_ckpt #(
    parameter int PREG_NUM    = 64,
    parameter int PREG_W      = 6,
    parameter int RD_PORTS    = 4,
    parameter int ALLOC_PORTS = 2,
    parameter int WB_PORTS    = 2,
    parameter int NUM_CKPT    = 4,
    parameter int CKPT_W      = 2
) (
    input logic               clock_i,
    input logic               reset_i,
    busytable_ckpt_if.slave   bus
);
    logic [PREG_NUM-1:0] tbl_q, tbl_d;
    logic [PREG_NUM-1:0] snap_q [NUM_CKPT];
    logic [PREG_NUM-1:0] snap_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic                err_q, err_d;

    logic [PREG_NUM-1:0] wb_vec;
    logic [PREG_NUM-1:0] alloc_vec;
    logic [PREG_NUM-1:0] take_alloc_vec;
    logic                same_id_rel;

    always_comb begin
        wb_vec         = '0;
        alloc_vec      = '0;
        take_alloc_vec = '0;
        for (int j = 0; j < WB_PORTS; j++) begin
            if (bus.wb_en[j]) wb_vec[bus.wb_addr[j*PREG_W +: PREG_W]] = 1'b1;
        end
        for (int j = 0; j < ALLOC_PORTS; j++) begin
            if (bus.alloc_en[j]) begin
                alloc_vec[bus.alloc_addr[j*PREG_W +: PREG_W]] = 1'b1;
                if (bus.ckpt_take_mask[j])
                    take_alloc_vec[bus.alloc_addr[j*PREG_W +: PREG_W]] = 1'b1;
            end
        end
    end

    // Same-cycle wakeup bypass; allocs in this cycle are deliberately not visible.
    always_comb begin
        bus.busy_out = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            bus.busy_out[i] = tbl_q[bus.read_addr[i*PREG_W +: PREG_W]]
                            & ~wb_vec[bus.read_addr[i*PREG_W +: PREG_W]];
        end
    end

    assign bus.ckpt_valid = valid_q;
    assign bus.ckpt_error = err_q;
    assign same_id_rel    = bus.ckpt_release && (bus.ckpt_release_id == bus.ckpt_take_id);

    always_comb begin
        tbl_d   = tbl_q;
        valid_d = valid_q;
        err_d   = err_q;
        for (int k = 0; k < NUM_CKPT; k++) snap_d[k] = snap_q[k];

        if (bus.flush) begin
            tbl_d   = '0;
            valid_d = '0;
        end else begin
            // Snapshots absorb wakeups so a later restore never resurrects stale busy bits.
            for (int k = 0; k < NUM_CKPT; k++) snap_d[k] = snap_q[k] & ~wb_vec;

            if (bus.restore_en) begin
                if (valid_q[bus.restore_id]) tbl_d = snap_q[bus.restore_id] & ~wb_vec;
                else                         err_d = 1'b1;
                valid_d[bus.restore_id] = 1'b0;
                valid_d = valid_d & ~bus.restore_kill_mask;
            end else begin
                tbl_d = (tbl_q | alloc_vec) & ~wb_vec;
                if (bus.ckpt_release) begin
                    if (!valid_q[bus.ckpt_release_id]) err_d = 1'b1;
                    valid_d[bus.ckpt_release_id] = 1'b0;
                end
                if (bus.ckpt_take) begin
                    if (valid_q[bus.ckpt_take_id] && !same_id_rel) err_d = 1'b1;
                    snap_d[bus.ckpt_take_id]  = (tbl_q | take_alloc_vec) & ~wb_vec;
                    valid_d[bus.ckpt_take_id] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tbl_q   <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) snap_q[k] <= '0;
        end else begin
            tbl_q   <= tbl_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int k = 0; k < NUM_CKPT; k++) snap_q[k] <= snap_d[k];
        end
    end
endmodule

// File: tb/tb_busytable_ckpt.sv
// tb/tb_busytable_ckpt.sv - directed bench for busytable_ckpt with a per-cycle reference model
module tb_busytable_ckpt;
    localparam int PREG_NUM    = 64;
    localparam int PREG_W      = 6;
    localparam int RD_PORTS    = 4;
    localparam int ALLOC_PORTS = 2;
    localparam int WB_PORTS    = 2;
    localparam int NUM_CKPT    = 4;
    localparam int CKPT_W      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    busytable_ckpt_if #(.PREG_W(PREG_W), .RD_PORTS(RD_PORTS), .ALLOC_PORTS(ALLOC_PORTS),
                        .WB_PORTS(WB_PORTS), .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)) bif ();

    busytable_ckpt #(.PREG_NUM(PREG_NUM), .PREG_W(PREG_W), .RD_PORTS(RD_PORTS),
                     .ALLOC_PORTS(ALLOC_PORTS), .WB_PORTS(WB_PORTS),
                     .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    bit mtbl  [PREG_NUM];
    bit msnap [NUM_CKPT][PREG_NUM];
    bit mvalid[NUM_CKPT];
    bit merr;

    function automatic int rd_a(input int i);
        logic [RD_PORTS*PREG_W-1:0] v;
        v = bif.read_addr;
        return int'(v[i*PREG_W +: PREG_W]);
    endfunction

    function automatic bit wb_hits(input int a);
        logic [WB_PORTS*PREG_W-1:0] v;
        v = bif.wb_addr;
        for (int j = 0; j < WB_PORTS; j++)
            if (bif.wb_en[j] && int'(v[j*PREG_W +: PREG_W]) == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_compare();
        logic [RD_PORTS-1:0] eb;
        logic [NUM_CKPT-1:0] ev;
        for (int i = 0; i < RD_PORTS; i++) eb[i] = mtbl[rd_a(i)] && !wb_hits(rd_a(i));
        for (int k = 0; k < NUM_CKPT; k++) ev[k] = mvalid[k];
        check("busy_out", int'(bif.busy_out), int'(eb));
        check("ckpt_valid", int'(bif.ckpt_valid), int'(ev));
        check("ckpt_error", int'(bif.ckpt_error), int'(merr));
    endtask

    task automatic model_update();
        bit ntbl[PREG_NUM];
        bit tsnap[PREG_NUM];
        logic [ALLOC_PORTS*PREG_W-1:0] aa;
        int tid, rid;
        aa = bif.alloc_addr;
        if (rst) begin
            mtbl = '{default: 1'b0}; msnap = '{default: '{default: 1'b0}};
            mvalid = '{default: 1'b0}; merr = 1'b0;
            return;
        end
        if (bif.flush) begin
            mtbl = '{default: 1'b0}; mvalid = '{default: 1'b0};
            return;
        end
        for (int k = 0; k < NUM_CKPT; k++)
            for (int p = 0; p < PREG_NUM; p++)
                if (mvalid[k] && wb_hits(p)) msnap[k][p] = 1'b0;
        if (bif.restore_en) begin
            rid = int'(bif.restore_id);
            if (mvalid[rid]) begin
                for (int p = 0; p < PREG_NUM; p++) mtbl[p] = msnap[rid][p] && !wb_hits(p);
            end else merr = 1'b1;
            mvalid[rid] = 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) if (bif.restore_kill_mask[k]) mvalid[k] = 1'b0;
            return;
        end
        ntbl  = mtbl;
        tsnap = mtbl;
        for (int j = 0; j < ALLOC_PORTS; j++) if (bif.alloc_en[j]) begin
            ntbl[int'(aa[j*PREG_W +: PREG_W])] = 1'b1;
            if (bif.ckpt_take_mask[j]) tsnap[int'(aa[j*PREG_W +: PREG_W])] = 1'b1;
        end
        for (int p = 0; p < PREG_NUM; p++) if (wb_hits(p)) begin
            ntbl[p] = 1'b0; tsnap[p] = 1'b0;
        end
        if (bif.ckpt_release) begin
            if (!mvalid[int'(bif.ckpt_release_id)]) merr = 1'b1;
            mvalid[int'(bif.ckpt_release_id)] = 1'b0;
        end
        if (bif.ckpt_take) begin
            tid = int'(bif.ckpt_take_id);
            if (mvalid[tid]) merr = 1'b1;
            msnap[tid]  = tsnap;
            mvalid[tid] = 1'b1;
        end
        mtbl = ntbl;
    endtask

    task automatic clear_inputs();
        bif.alloc_en = '0; bif.alloc_addr = '0; bif.wb_en = '0; bif.wb_addr = '0;
        bif.ckpt_take = 1'b0; bif.ckpt_take_id = '0; bif.ckpt_take_mask = '0;
        bif.ckpt_release = 1'b0; bif.ckpt_release_id = '0;
        bif.restore_en = 1'b0; bif.restore_id = '0; bif.restore_kill_mask = '0;
        bif.flush = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #1;
        clear_inputs();
    endtask

    task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
        bif.read_addr = {PREG_W'(a3), PREG_W'(a2), PREG_W'(a1), PREG_W'(a0)};
        #1;
    endtask

    task automatic alloc(input int port, input int a);
        bif.alloc_en[port] = 1'b1;
        bif.alloc_addr[port*PREG_W +: PREG_W] = PREG_W'(a);
    endtask

    task automatic wb(input int port, input int a);
        bif.wb_en[port] = 1'b1;
        bif.wb_addr[port*PREG_W +: PREG_W] = PREG_W'(a);
    endtask

    task automatic take(input int id, input int mask);
        bif.ckpt_take = 1'b1; bif.ckpt_take_id = CKPT_W'(id); bif.ckpt_take_mask = ALLOC_PORTS'(mask);
    endtask

    task automatic restore(input int id, input int kill);
        bif.restore_en = 1'b1; bif.restore_id = CKPT_W'(id); bif.restore_kill_mask = NUM_CKPT'(kill);
    endtask

    initial begin
        clear_inputs();
        bif.read_addr = '0;
        // Reset cycle also carries an alloc that must be discarded.
        rst = 1'b1;
        alloc(0, 1);
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;
        clear_inputs();

        set_reads(1, 5, 9, 63);
        check("reset_busy", int'(bif.busy_out), 0);
        check("reset_valid", int'(bif.ckpt_valid), 0);
        check("reset_err", int'(bif.ckpt_error), 0);

        alloc(0, 5); alloc(1, 9); tick();
        set_reads(5, 9, 0, 63);
        check("alloc_read", int'(bif.busy_out), 4'b0011);

        alloc(0, 12); tick();
        set_reads(12, 12, 5, 0);
        wb(1, 12); #1;
        check("wb_bypass", int'(bif.busy_out), 4'b0100);
        tick();

        alloc(0, 20); wb(0, 20); tick();
        set_reads(20, 12, 9, 5);
        check("wb_beats_alloc", int'(bif.busy_out), 4'b1100);

        alloc(0, 3); alloc(1, 4); take(1, 1); tick();
        set_reads(3, 4, 7, 5);
        check("take_tbl", int'(bif.busy_out), 4'b1011);
        check("take_valid", int'(bif.ckpt_valid), 4'b0010);
        alloc(0, 7); tick();
        restore(1, 0); tick();
        check("restore1_busy", int'(bif.busy_out), 4'b1001);
        check("restore1_valid", int'(bif.ckpt_valid), 4'b0000);

        alloc(1, 8); tick();
        take(2, 0); tick();
        tick();
        wb(0, 8); tick();
        alloc(0, 8); tick();
        restore(2, 0); tick();
        set_reads(8, 3, 5, 9);
        check("snap_wakeup", int'(bif.busy_out), 4'b1110);

        take(0, 0); tick();
        take(1, 0); tick();
        take(2, 0); tick();
        check("three_valid", int'(bif.ckpt_valid), 4'b0111);
        restore(0, 4'b0110); tick();
        check("kill_valid", int'(bif.ckpt_valid), 4'b0000);

        for (int p = 1; p <= 10; p += 2) begin
            alloc(0, p); alloc(1, p + 1); tick();
        end
        take(3, 0); tick();
        set_reads(1, 2, 9, 10);
        check("pre_flush", int'(bif.busy_out), 4'b1111);
        bif.flush = 1'b1; alloc(0, 40); take(0, 0); tick();
        check("flush_busy", int'(bif.busy_out), 4'b0000);
        check("flush_valid", int'(bif.ckpt_valid), 4'b0000);
        check("flush_err", int'(bif.ckpt_error), 0);

        take(3, 0); tick();
        take(3, 0); bif.ckpt_release = 1'b1; bif.ckpt_release_id = 2'd3; tick();
        check("take_rel_err", int'(bif.ckpt_error), 0);
        check("take_rel_valid", int'(bif.ckpt_valid), 4'b1000);
        take(3, 0); tick();
        check("double_take_err", int'(bif.ckpt_error), 1);
        bif.flush = 1'b1; tick();
        check("err_sticky", int'(bif.ckpt_error), 1);

        rst = 1'b1; tick();
        rst = 1'b0;
        check("err_reset", int'(bif.ckpt_error), 0);
        alloc(1, 30); tick();
        restore(2, 0); tick();
        set_reads(30, 0, 0, 0);
        check("bad_restore_err", int'(bif.ckpt_error), 1);
        check("bad_restore_tbl", int'(bif.busy_out), 4'b0001);
        bif.ckpt_release = 1'b1; bif.ckpt_release_id = 2'd1; tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/busytable_ckpt.md
# busytable_ckpt

Parametrised physical-register busy table for the dispatch stage, successor to the fixed 4-read/2-alloc/2-free busy table. It tracks one busy bit per physical register, sets bits on rename allocation and clears them on writeback wakeup. It adds a bank of per-branch checkpoints, so a mispredict restores the table in one cycle instead of rebuilding it through a ROB walk. Port counts and table depth are parameters.

## Interface
- PREG_NUM, 64, number of physical registers
- PREG_W, 6, physical register index width (clog2 PREG_NUM)
- RD_PORTS, 4, read ports
- ALLOC_PORTS, 2, allocation ports; index 0 is oldest in the rename group
- WB_PORTS, 2, writeback/wakeup ports
- NUM_CKPT, 4, checkpoint slots
- CKPT_W, 2, checkpoint id width (clog2 NUM_CKPT)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- read_addr  in  RD_PORTS*PREG_W  packed read indices, port i at [i*PREG_W +: PREG_W]
- busy_out  out  RD_PORTS  combinational busy per read port
- alloc_en  in  ALLOC_PORTS  allocate (set busy)
- alloc_addr  in  ALLOC_PORTS*PREG_W  packed allocation indices
- wb_en  in  WB_PORTS  wakeup (clear busy)
- wb_addr  in  WB_PORTS*PREG_W  packed wakeup indices
- ckpt_take  in  1  capture a checkpoint this cycle
- ckpt_take_id  in  CKPT_W  slot to capture into
- ckpt_take_mask  in  ALLOC_PORTS  alloc ports older than the branch; only these are included in the snapshot
- ckpt_release  in  1  branch resolved correct; free the slot
- ckpt_release_id  in  CKPT_W  slot to free
- restore_en  in  1  mispredict; restore the table from a slot
- restore_id  in  CKPT_W  slot to restore from
- restore_kill_mask  in  NUM_CKPT  slots younger than the mispredicted branch; these are invalidated
- flush  in  1  full pipeline flush: clear all busy bits
- ckpt_valid  out  NUM_CKPT  registered slot-valid vector
- ckpt_error  out  1  sticky protocol-error flag, registered

## Operation
- State: table[PREG_NUM], snap[NUM_CKPT][PREG_NUM], valid[NUM_CKPT], err.
- Update priority is reset > flush > restore > normal.
- reset:
  - table, all snaps, valid and err are cleared to 0.
  - All outputs read 0 the cycle after reset is sampled.
- flush:
  - table and valid are cleared; err is held.
  - All other inputs are ignored that cycle.
- restore_en:
  - table_next = snap[restore_id] with every wb_en address cleared.
  - valid[restore_id] and the restore_kill_mask bits are cleared.
  - alloc_en, ckpt_take and ckpt_release are ignored that cycle.
  - Restoring an invalid slot sets err and leaves table unchanged.
- Normal cycle:
  - table_next = table, then allocated addresses are set, then wakeup addresses are cleared.
  - Wakeup wins over alloc on the same address.
- Wakeup into checkpoints: every cycle except reset/flush, each valid snap clears its bits for all wb_en addresses, so snapshots never hold stale busy bits.
- ckpt_take:
  - snap[id] = table | (allocs on ports with mask=1), then minus the wakeup addresses.
  - valid[id] is set.
  - Taking an already-valid id sets err and still overwrites the slot.
- ckpt_release clears valid[id]. Releasing an invalid id sets err.
- Take and release on the same id in the same cycle: the release is applied first, then the take. No error; the slot ends valid.
- busy_out[i] = table[read_addr[i]] AND NOT (any wb_en[j] with wb_addr[j]==read_addr[i]). This is the same-cycle wakeup bypass.
- busy_out does not see same-cycle allocs; rename resolves intra-group dependences.
- During restore/flush cycles busy_out reflects the pre-update table. Rename is stalled by the control logic in those cycles.
- Duplicate addresses across ports of the same type are legal; the result is idempotent.

## Timing
- Read: 0-cycle combinational path addr -> busy_out, including the wb bypass.
- All writes (alloc, wb, take, release, restore, flush) become visible on busy_out and ckpt_valid one cycle after the sampling edge.
- Restore latency is 1 cycle: rename may resume the cycle after restore_en.
- Reset mid-operation (during a take or restore) discards that cycle's update entirely.
- ckpt_error stays set until reset.

## Test plan
- **Reset**: assert reset 1 cycle -> busy_out=0000, ckpt_valid=0000, ckpt_error=0. Then alloc p5,p9; next cycle reads 5,9,0,63 -> busy_out=0011 (bit0 = port0).
- **Bypass/priority**:
  - p12 busy; wb_en p12 with read p12 in the same cycle -> busy_out=0 that cycle.
  - Alloc p20 and wb p20 in the same cycle -> p20 not busy the next cycle.
- **Checkpoint take/restore**:
  - alloc p3 (port0) + p4 (port1) with take id1, mask=01 -> snap1 holds p3 only.
  - Later alloc p7; restore id1 -> next cycle p3 busy, p4 and p7 not busy, ckpt_valid[1]=0.
- **Snapshot wakeup**: take id2 with p8 busy; wb p8 two cycles later; restore id2 -> p8 not busy.
- **Kill mask / flush**:
  - Valid slots 0,1,2; restore id0 with kill_mask=0110 -> ckpt_valid=0000.
  - flush with p1..p10 busy -> all reads 0 the next cycle.
- **Errors**:
  - Take id3 twice -> ckpt_error=1 from the following cycle.
  - Take+release id3 in the same cycle (id3 valid) -> no error, ckpt_valid[3]=1.
